// File: rtl/alu_pkg.sv
// Shared constants and operation encodings
// for the stage-2 ALU execute slice.
package alu_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    localparam logic [2:0] SHIFT_REG   = 3'b000;
    localparam logic [2:0] ARITH_LOGIC = 3'b001;
    localparam logic [2:0] MEM_READ    = 3'b101;
    localparam logic [2:0] MEM_WRITE   = 3'b100;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_HADD = 3'b001,
        OP_SUB  = 3'b010,
        OP_NOT  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_LHG  = 3'b111
    } arith_op_e;

    typedef enum logic [2:0] {
        LD_BYTE  = 3'b000,
        LD_BYTEU = 3'b001,
        LD_HALF  = 3'b010,
        LD_HALFU = 3'b011,
        LD_WORD  = 3'b100
    } load_op_e;

    typedef enum logic [1:0] {
        SH_LEFT0 = 2'b00,
        SH_LEFT1 = 2'b01,
        SH_RLOG  = 2'b10,
        SH_RART  = 2'b11
    } shift_op_e;

endpackage

// File: rtl/stage2_alu_execute_if.sv
// Operand/result bundle between operand-prep
// stage, the ALU stage and writeback.
interface stage2_alu_execute_if
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
);
    logic               enable_arith;
    logic               enable_shift;
    logic [WIDTH-1:0]   aluin1;
    logic [WIDTH-1:0]   aluin2;
    logic [2:0]         operation;
    logic [2:0]         opselect;
    logic [SHAMT_W-1:0] shift_number;
    logic [WIDTH-1:0]   aluout;
    logic               carry;
    logic               overflow;
    logic               result_valid;

    modport master (
        output enable_arith, enable_shift,
        output aluin1, aluin2,
        output operation, opselect, shift_number,
        input  aluout, carry, overflow, result_valid
    );

    modport slave (
        input  enable_arith, enable_shift,
        input  aluin1, aluin2,
        input  operation, opselect, shift_number,
        output aluout, carry, overflow, result_valid
    );
endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: left, logical
// right and arithmetic right.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shift_number,
    input  logic [1:0]         shift_op,
    output logic [WIDTH-1:0]   y
);
    always_comb begin
        y = a;
        unique case (shift_op_e'(shift_op))
            SH_LEFT0,
            SH_LEFT1: y = a << shift_number;
            SH_RLOG:  y = a >> shift_number;
            SH_RART:  y = WIDTH'($signed(a) >>> shift_number);
            default:  y = a;
        endcase
    end
endmodule

// File: rtl/stage2_alu_execute.sv
// Registered ALU stage: arith/logic, load
// formatting and shifts with carry/overflow.
module stage2_alu_execute
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input logic                 clock,
    input logic                 reset,
    stage2_alu_execute_if.slave bus
);
    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] shift_y;
    logic [WIDTH:0]   sum, diff;
    logic [16:0]      hsum;
    logic             sel_arith, sel_mem, sel_shift;
    logic [WIDTH-1:0] arith_y, load_y;
    logic             arith_c, arith_o;

    assign a = bus.aluin1;
    assign b = bus.aluin2;

    assign sel_arith = bus.enable_arith
                    && bus.opselect == ARITH_LOGIC;
    assign sel_mem   = bus.enable_arith
                    && bus.opselect == MEM_READ;
    // Shift codes 1xx are reserved and behave as no-op
    assign sel_shift = bus.enable_shift
                    && bus.opselect == SHIFT_REG
                    && !bus.operation[2];

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign hsum = {1'b0, a[15:0]} + {1'b0, b[15:0]};

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .a            (a),
        .shift_number (bus.shift_number),
        .shift_op     (bus.operation[1:0]),
        .y            (shift_y)
    );

    always_comb begin
        arith_y = '0;
        arith_c = 1'b0;
        arith_o = 1'b0;
        unique case (arith_op_e'(bus.operation))
            OP_ADD: begin
                arith_y = sum[WIDTH-1:0];
                arith_c = sum[WIDTH];
                arith_o = (a[WIDTH-1] == b[WIDTH-1])
                       && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_HADD: begin
                arith_y = {{(WIDTH-16){hsum[15]}},
                           hsum[15:0]};
                arith_c = hsum[16];
                arith_o = (a[15] == b[15])
                       && (hsum[15] != a[15]);
            end
            OP_SUB: begin
                arith_y = diff[WIDTH-1:0];
                arith_c = diff[WIDTH];
                arith_o = (a[WIDTH-1] != b[WIDTH-1])
                       && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT: arith_y = ~b;
            OP_AND: arith_y = a & b;
            OP_OR:  arith_y = a | b;
            OP_XOR: arith_y = a ^ b;
            OP_LHG: arith_y = {b[15:0],
                               {(WIDTH-16){1'b0}}};
            default: arith_y = '0;
        endcase
    end

    always_comb begin
        load_y = b;
        case (load_op_e'(bus.operation))
            LD_BYTE:  load_y = {{(WIDTH-8){b[7]}}, b[7:0]};
            LD_BYTEU: load_y = {{(WIDTH-8){1'b0}}, b[7:0]};
            LD_HALF:  load_y = {{(WIDTH-16){b[15]}}, b[15:0]};
            LD_HALFU: load_y = {{(WIDTH-16){1'b0}}, b[15:0]};
            default:  load_y = b;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.aluout       <= '0;
            bus.carry        <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.result_valid <= 1'b0;
        end else begin
            bus.result_valid <= 1'b0;
            if (sel_arith) begin
                bus.aluout       <= arith_y;
                bus.carry        <= arith_c;
                bus.overflow     <= arith_o;
                bus.result_valid <= 1'b1;
            end else if (sel_mem) begin
                bus.aluout       <= load_y;
                bus.carry        <= 1'b0;
                bus.overflow     <= 1'b0;
                bus.result_valid <= 1'b1;
            end else if (sel_shift) begin
                bus.aluout       <= shift_y;
                bus.result_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stage2_alu_execute.sv
// Directed bench for the stage-2 ALU execute
// block with hand-computed expectations.
module tb_stage2_alu_execute;
    import alu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    stage2_alu_execute_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    stage2_alu_execute #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag,
                              input logic [31:0] y,
                              input logic c,
                              input logic o,
                              input logic v);
        chk({tag, ".aluout"}, bus.aluout, y);
        chk({tag, ".carry"}, {31'b0, bus.carry}, {31'b0, c});
        chk({tag, ".ovf"}, {31'b0, bus.overflow}, {31'b0, o});
        chk({tag, ".valid"}, {31'b0, bus.result_valid}, {31'b0, v});
    endtask

    task automatic drive(input logic ea, input logic es,
                         input logic [2:0] sel,
                         input logic [2:0] op,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input logic [4:0] sh);
        bus.enable_arith = ea;
        bus.enable_shift = es;
        bus.opselect     = sel;
        bus.operation    = op;
        bus.aluin1       = x;
        bus.aluin2       = y;
        bus.shift_number = sh;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 3'b000, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        idle();
        tick();
        expect_out("rst1", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("rst2", 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("idle0", 32'h0, 1'b0, 1'b0, 1'b0);

        drive(1, 0, ARITH_LOGIC, 3'b000, 32'h7FFF_FFFF, 32'h1, 0);
        tick();
        expect_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        idle();
        tick();
        expect_out("hold", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        drive(1, 0, ARITH_LOGIC, 3'b010, 32'd5, 32'd7, 0);
        tick();
        expect_out("sub", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
        drive(1, 0, ARITH_LOGIC, 3'b110, 32'hF0F0_F0F0,
              32'hFFFF_0000, 0);
        tick();
        expect_out("xor", 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b1);

        drive(1, 0, MEM_READ, 3'b000, 32'h0, 32'h0000_0080, 0);
        tick();
        expect_out("lb", 32'hFFFF_FF80, 1'b0, 1'b0, 1'b1);
        drive(1, 0, MEM_READ, 3'b011, 32'h0, 32'h1234_8001, 0);
        tick();
        expect_out("lhu", 32'h0000_8001, 1'b0, 1'b0, 1'b1);
        drive(1, 0, MEM_READ, 3'b110, 32'h0, 32'hCAFE_F00D, 0);
        tick();
        expect_out("lw", 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);

        drive(1, 0, ARITH_LOGIC, 3'b000, 32'hFFFF_FFFF, 32'h1, 0);
        tick();
        expect_out("add_wrap", 32'h0, 1'b1, 1'b0, 1'b1);

        drive(0, 1, SHIFT_REG, 3'b011, 32'h8000_0010, 32'h0, 5'd4);
        tick();
        expect_out("sra4", 32'hF800_0001, 1'b1, 1'b0, 1'b1);
        drive(0, 1, SHIFT_REG, 3'b000, 32'h1234_5678, 32'h0, 5'd0);
        tick();
        expect_out("sll0", 32'h1234_5678, 1'b1, 1'b0, 1'b1);
        drive(0, 1, SHIFT_REG, 3'b011, 32'h8000_0000, 32'h0, 5'd31);
        tick();
        expect_out("sra31", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
        drive(0, 1, SHIFT_REG, 3'b010, 32'h8000_0000, 32'h0, 5'd31);
        tick();
        expect_out("srl31", 32'h0000_0001, 1'b1, 1'b0, 1'b1);
        drive(0, 1, SHIFT_REG, 3'b101, 32'hFFFF_FFFF, 32'h0, 5'd1);
        tick();
        expect_out("sh_rsv", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        drive(1, 0, SHIFT_REG, 3'b000, 32'd9, 32'd9, 5'd1);
        tick();
        expect_out("mismatch", 32'h0000_0001, 1'b1, 1'b0, 1'b0);

        drive(1, 1, ARITH_LOGIC, 3'b000, 32'd3, 32'd4, 5'd2);
        tick();
        expect_out("both_en", 32'd7, 1'b0, 1'b0, 1'b1);

        drive(1, 0, ARITH_LOGIC, 3'b001, 32'h0000_7FFF, 32'h1, 0);
        tick();
        expect_out("hadd", 32'hFFFF_8000, 1'b0, 1'b1, 1'b1);
        drive(1, 0, ARITH_LOGIC, 3'b111, 32'h0, 32'h0000_ABCD, 0);
        tick();
        expect_out("lhg", 32'hABCD_0000, 1'b0, 1'b0, 1'b1);
        drive(1, 0, ARITH_LOGIC, 3'b011, 32'h0, 32'h0F0F_0000, 0);
        tick();
        expect_out("not", 32'hF0F0_FFFF, 1'b0, 1'b0, 1'b1);

        drive(1, 0, ARITH_LOGIC, 3'b000, 32'd1, 32'd1, 0);
        reset = 1'b1;
        tick();
        expect_out("rst_op", 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        idle();
        tick();
        expect_out("post_rst", 32'h0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stage2_alu_execute.md
Name: stage2_alu_execute

Overview:
- Registered ALU stage that sits directly downstream of the execute/operand-preparation stage.
- Consumes its registered outputs: operands aluin1/aluin2, operation, opselect, shift_number, enable_arith, enable_shift.
- Performs arithmetic, logic, load-format or shift operations and registers the result with carry/overflow flags.
- Result feeds writeback; one-cycle latency, fully registered outputs.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- SHAMT_W, 5, shift-amount width (log2 WIDTH).

Ports:
- clock  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable_arith  input  1  perform arith/logic/load-format op this cycle.
- enable_shift  input  1  perform shift op this cycle.
- aluin1  input  WIDTH  operand 1 (register source).
- aluin2  input  WIDTH  operand 2 (register, immediate or memory read data).
- operation  input  3  op code within class.
- opselect  input  3  class: 000 SHIFT_REG, 001 ARITH_LOGIC, 101 MEM_READ.
- shift_number  input  SHAMT_W  shift amount.
- aluout  output  WIDTH  registered result.
- carry  output  1  registered carry/borrow flag.
- overflow  output  1  registered signed-overflow flag.
- result_valid  output  1  one-cycle pulse: aluout updated this cycle.

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clock. All state updates on posedge clock.
- Reset: aluout=0, carry=0, overflow=0, result_valid=0. Reset has priority over every enable; a reset cycle mid-stream discards the in-flight op, and no valid pulse follows it.
- Latency: inputs sampled at edge N; results visible after edge N; result_valid high for exactly that cycle.
- Dispatch priority:
  - enable_arith && opselect==ARITH_LOGIC → arith/logic unit.
  - else enable_arith && opselect==MEM_READ → load-format unit.
  - else enable_shift && opselect==SHIFT_REG → shifter.
  - else no op.
  - Both enables high: arith path wins.
  - Enable high with a mismatched opselect: no op.
- No op: aluout, carry and overflow hold; result_valid=0.
- ARITH_LOGIC operation codes:
  - 000 ADD: aluout=a+b mod 2^32; carry=bit32 of unsigned sum; overflow=signed add overflow.
  - 001 HADD: 16-bit add of a[15:0]+b[15:0]; aluout=sign-extended 16-bit sum; carry=bit16; overflow=16-bit signed overflow.
  - 010 SUB: aluout=a-b; carry=1 iff a<b unsigned (borrow); overflow=signed sub overflow.
  - 011 NOT: aluout=~b.
  - 100 AND; 101 OR; 110 XOR: bitwise on a, b.
  - 111 LHG: aluout={b[15:0],16'h0}.
  - Flag rule: logic ops and LHG clear carry and overflow.
- MEM_READ operation codes, applied to b (memory data):
  - 000 LOADBYTE: sign-extend b[7:0].
  - 001 LOADBYTEU: zero-extend b[7:0].
  - 010 LOADHALF: sign-extend b[15:0].
  - 011 LOADHALFU: zero-extend b[15:0].
  - 1xx LOADWORD: aluout=b.
  - Flags: carry and overflow cleared.
- SHIFT_REG operation codes, applied to a by shift_number:
  - 000 and 001 SHLEFT: logical left shift.
  - 010 SHRIGHTLOG: logical right shift.
  - 011 SHRIGHTART: arithmetic right shift, sign-filled from a[31].
  - 1xx: no op; holds, result_valid=0.
  - Flags: carry and overflow hold on shifts.
  - shift_number=0: aluout=a. shift_number=31 with SHRIGHTART on negative a: 32'hFFFF_FFFF.
- Wrap-around: ADD of 32'hFFFF_FFFF+1 gives 0 with carry=1. No saturation anywhere.

Decomposition:
- Shared package alu_pkg:
  - opselect constants SHIFT_REG, ARITH_LOGIC, MEM_READ, MEM_WRITE.
  - Enums for arith, load and shift operation codes.
  - WIDTH/SHAMT_W defaults.
- Sub-module alu_shifter: purely combinational barrel shifter (a, shift_number, operation → shifted value). Instantiated once.
- Arithmetic, load formatting and output registers stay in the top module.

Test Plan:
- Reset held 2 cycles, then released with no enables → aluout=0, carry=0, overflow=0, result_valid=0 throughout.
- ARITH ADD, a=32'h7FFF_FFFF, b=1 → next cycle aluout=32'h8000_0000, carry=0, overflow=1, result_valid=1. Following idle cycle → values hold, result_valid=0.
- ARITH SUB, a=5, b=7 → aluout=32'hFFFF_FFFE, carry=1, overflow=0. Then XOR with a=32'hF0F0_F0F0, b=32'hFFFF_0000 → aluout=32'h0F0F_F0F0, carry=0, overflow=0.
- MEM_READ LOADBYTE, b=32'h0000_0080 → aluout=32'hFFFF_FF80. LOADHALFU, b=32'h1234_8001 → aluout=32'h0000_8001.
- SHIFT SHRIGHTART, a=32'h8000_0010, shift_number=4 → aluout=32'hF800_0001; carry/overflow keep prior values. SHLEFT with shift_number=0 → aluout=a.
- Both enables high with opselect=ARITH_LOGIC ADD 3+4 → aluout=7. Next, an op issued in the same cycle as reset asserts → all outputs 0 and no result_valid pulse.
